divider_share_ctrl: RTL

- Arbitrates one shared Iterative_Divider between two requesters: the frequency path (500_000_000 / period_time) and the period path (period_time / 5000).
- Lets Measurement_Processor drop its second divider.
- Latches requests, grants the divider round-robin, issues a one-cycle start, and collects the result.
- Returns each quotient on a per-channel done pulse, with divide-by-zero and timeout protection.

---
 rtl/divider_share_ctrl_pkg.sv | 28 ++
 rtl/div_req_slot.sv | 46 ++++
 rtl/divider_share_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/divider_share_ctrl_pkg.sv
// Shared types and constants for the divider-sharing arbiter.
package divider_share_ctrl_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned DIV_TIMEOUT = 48;
    localparam int unsigned TMO_W       = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } state_e;

    localparam logic CH_FREQ   = 1'b0;
    localparam logic CH_PERIOD = 1'b1;

    localparam logic [DATA_W-1:0] ERR_QUOT = '1;

    // Last WAIT cycle index before the operation is abandoned.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DIV_TIMEOUT - 1);

    typedef struct packed {
        logic [DATA_W-1:0] num;
        logic [DATA_W-1:0] den;
    } div_op_t;

endpackage

// File: rtl/div_req_slot.sv
// Per-channel request latch: a pending flag plus the latest operands.
module div_req_slot
    import divider_share_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [DATA_W-1:0] num,
    input  logic [DATA_W-1:0] den,
    input  logic              take,
    output logic              pend,
    output div_op_t           op,
    output logic              pend_nxt_c
);

    logic    pend_q, pend_d;
    div_op_t op_q, op_d;

    // A new request beats a simultaneous take: it becomes the follow-up run.
    always_comb begin
        pend_d = pend_q;
        op_d   = op_q;
        if (take) begin
            pend_d = 1'b0;
        end
        if (req) begin
            pend_d = 1'b1;
            op_d   = '{num: num, den: den};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
            op_q   <= '0;
        end else begin
            pend_q <= pend_d;
            op_q   <= op_d;
        end
    end

    assign pend       = pend_q;
    assign op         = op_q;
    assign pend_nxt_c = pend_d;

endmodule

// File: rtl/divider_share_ctrl.sv
// Round-robin arbiter sharing one iterative divider between the frequency
// and period channels, with divide-by-zero and timeout protection.
module divider_share_ctrl
    import divider_share_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [DATA_W-1:0] f_num,
    input  logic [DATA_W-1:0] f_den,
    input  logic              p_req,
    input  logic [DATA_W-1:0] p_num,
    input  logic [DATA_W-1:0] p_den,
    output logic [DATA_W-1:0] f_quot,
    output logic              f_done,
    output logic              f_err,
    output logic [DATA_W-1:0] p_quot,
    output logic              p_done,
    output logic              p_err,
    output logic              div_start,
    output logic [DATA_W-1:0] div_num,
    output logic [DATA_W-1:0] div_den,
    input  logic [DATA_W-1:0] div_quot,
    input  logic              div_done,
    output logic              busy
);

    state_e            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    div_op_t           op_q, op_d;
    logic              div_start_q, div_start_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              res_err_q, res_err_d;
    logic [DATA_W-1:0] f_quot_q, f_quot_d, p_quot_q, p_quot_d;
    logic              f_done_q, f_done_d, p_done_q, p_done_d;
    logic              f_err_q, f_err_d, p_err_q, p_err_d;
    logic              busy_q, busy_d;

    logic              take_f, take_p;
    logic              f_pend, p_pend, f_pend_nxt, p_pend_nxt;
    div_op_t           f_op, p_op;

    div_req_slot u_slot_f (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (f_req),
        .num        (f_num),
        .den        (f_den),
        .take       (take_f),
        .pend       (f_pend),
        .op         (f_op),
        .pend_nxt_c (f_pend_nxt)
    );

    div_req_slot u_slot_p (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (p_req),
        .num        (p_num),
        .den        (p_den),
        .take       (take_p),
        .pend       (p_pend),
        .op         (p_op),
        .pend_nxt_c (p_pend_nxt)
    );

    // Arbiter next-state and registered-output decode.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        div_start_d  = 1'b0;
        tmo_d        = tmo_q;
        res_d        = res_q;
        res_err_d    = res_err_q;
        f_quot_d     = f_quot_q;
        f_err_d      = f_err_q;
        f_done_d     = 1'b0;
        p_quot_d     = p_quot_q;
        p_err_d      = p_err_q;
        p_done_d     = 1'b0;
        take_f       = 1'b0;
        take_p       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (f_pend || p_pend) begin
                    if (f_pend && p_pend) begin
                        grant_d = ~last_grant_q;
                    end else begin
                        grant_d = p_pend ? CH_PERIOD : CH_FREQ;
                    end
                    if (grant_d == CH_FREQ) begin
                        take_f = 1'b1;
                        op_d   = f_op;
                    end else begin
                        take_p = 1'b1;
                        op_d   = p_op;
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (op_q.den == '0) begin
                    res_d     = ERR_QUOT;
                    res_err_d = 1'b1;
                    state_d   = ST_DELIVER;
                end else begin
                    div_start_d = 1'b1;
                    tmo_d       = '0;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (div_done) begin
                    res_d     = div_quot;
                    res_err_d = 1'b0;
                    state_d   = ST_DELIVER;
                end else if (tmo_q == TMO_LAST) begin
                    res_d     = ERR_QUOT;
                    res_err_d = 1'b1;
                    state_d   = ST_DELIVER;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_DELIVER: begin
                if (grant_q == CH_FREQ) begin
                    f_quot_d = res_q;
                    f_err_d  = res_err_q;
                    f_done_d = 1'b1;
                end else begin
                    p_quot_d = res_q;
                    p_err_d  = res_err_q;
                    p_done_d = 1'b1;
                end
                last_grant_d = grant_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE) || f_pend_nxt || p_pend_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= CH_FREQ;
            last_grant_q <= CH_PERIOD;
            op_q         <= '0;
            div_start_q  <= 1'b0;
            tmo_q        <= '0;
            res_q        <= '0;
            res_err_q    <= 1'b0;
            f_quot_q     <= '0;
            f_err_q      <= 1'b0;
            f_done_q     <= 1'b0;
            p_quot_q     <= '0;
            p_err_q      <= 1'b0;
            p_done_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            div_start_q  <= div_start_d;
            tmo_q        <= tmo_d;
            res_q        <= res_d;
            res_err_q    <= res_err_d;
            f_quot_q     <= f_quot_d;
            f_err_q      <= f_err_d;
            f_done_q     <= f_done_d;
            p_quot_q     <= p_quot_d;
            p_err_q      <= p_err_d;
            p_done_q     <= p_done_d;
            busy_q       <= busy_d;
        end
    end

    assign f_quot    = f_quot_q;
    assign f_done    = f_done_q;
    assign f_err     = f_err_q;
    assign p_quot    = p_quot_q;
    assign p_done    = p_done_q;
    assign p_err     = p_err_q;
    assign div_start = div_start_q;
    assign div_num   = op_q.num;
    assign div_den   = op_q.den;
    assign busy      = busy_q;

endmodule
